// File: rtl/button_conditioner.sv
// button_conditioner: N-channel push-button / switch conditioner.
// Each channel passes through a 2-FF synchroniser and a polarity stage. A
// debounce FSM then turns the raw pad into a clean level plus one-cycle
// press, release and long-press strobes. Channels are fully independent.
//
// Ports:
//   clk_100m      in   1       system clock
//   rstn          in   1       asynchronous active-low reset
//   raw_in        in   NUM_CH  asynchronous pad inputs
//   level         out  NUM_CH  debounced pressed state (1 = pressed)
//   press_pulse   out  NUM_CH  1-cycle strobe on accepted press
//   release_pulse out  NUM_CH  1-cycle strobe on accepted release
//   long_pulse    out  NUM_CH  1-cycle strobe, once per press, after LONG_CYCLES held
//   long_held     out  NUM_CH  high from long_pulse until release is accepted
module button_conditioner #(
    parameter int unsigned NUM_CH          = 4,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000
) (
    input  logic              clk_100m,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] long_pulse,
    output logic [NUM_CH-1:0] long_held
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned LCNT_W = $clog2(LONG_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_CHK_PRESS = 2'd1,
        ST_PRESSED   = 2'd2,
        ST_CHK_REL   = 2'd3
    } state_e;

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] s_q, s_d;

    // Synchroniser chain followed by a polarity-normalising stage (1 = pressed).
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        s_d     = sync2_q ^ {NUM_CH{ACTIVE_LOW}};
    end

    always_ff @(posedge clk_100m or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_q     <= s_d;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_e            state_q, state_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [LCNT_W-1:0] lcnt_q, lcnt_d;
        logic [LCNT_W-1:0] lcnt_inc;
        logic              long_hit;
        logic              s;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        logic              held_q, held_d;

        assign s = s_q[ch];

        // Saturating hold counter; long_hit marks the single step onto the last value.
        assign lcnt_inc = (lcnt_q == LCNT_LAST) ? lcnt_q : lcnt_q + LCNT_W'(1);
        assign long_hit = (lcnt_q != LCNT_LAST) && (lcnt_inc == LCNT_LAST);

        always_ff @(posedge clk_100m or negedge rstn) begin
            if (!rstn) begin
                state_q   <= ST_RELEASED;
                dcnt_q    <= '0;
                lcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                lcnt_q    <= lcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                held_q    <= held_d;
            end
        end

        // Debounce FSM; the hold counter keeps running through release glitches.
        always_comb begin
            state_d   = state_q;
            dcnt_d    = dcnt_q;
            lcnt_d    = lcnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
            held_d    = held_q;

            case (state_q)
                ST_RELEASED: begin
                    if (s) begin
                        state_d = ST_CHK_PRESS;
                        dcnt_d  = '0;
                    end
                end

                ST_CHK_PRESS: begin
                    if (!s) begin
                        state_d = ST_RELEASED;
                    end else if (dcnt_q == DCNT_LAST) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        lcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + DCNT_W'(1);
                    end
                end

                ST_PRESSED: begin
                    lcnt_d = lcnt_inc;
                    if (long_hit) begin
                        long_d = 1'b1;
                        held_d = 1'b1;
                    end
                    if (!s) begin
                        state_d = ST_CHK_REL;
                        dcnt_d  = '0;
                    end
                end

                ST_CHK_REL: begin
                    if (!s && (dcnt_q == DCNT_LAST)) begin
                        // Release wins over a coincident long strobe.
                        state_d   = ST_RELEASED;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        held_d    = 1'b0;
                    end else begin
                        lcnt_d = lcnt_inc;
                        if (long_hit) begin
                            long_d = 1'b1;
                            held_d = 1'b1;
                        end
                        if (s) begin
                            state_d = ST_PRESSED;
                        end else begin
                            dcnt_d = dcnt_q + DCNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_RELEASED;
                end
            endcase
        end

        assign level[ch]         = level_q;
        assign press_pulse[ch]   = press_q;
        assign release_pulse[ch] = release_q;
        assign long_pulse[ch]    = long_q;
        assign long_held[ch]     = held_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: one active-high and one active-low instance,
// directed scenarios with timing anchors, then randomized pad activity, all
// compared every cycle against a run-length reference model.
module tb_button_conditioner;

    localparam int unsigned NCH = 4;
    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 32;

    logic           clk_100m = 1'b0;
    logic           rstn;
    logic [NCH-1:0] raw_a, raw_b;
    logic [NCH-1:0] a_level, a_press, a_rel, a_long, a_held;
    logic [NCH-1:0] b_level, b_press, b_rel, b_long, b_held;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100m = ~clk_100m;

    button_conditioner #(
        .NUM_CH(NCH), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)
    ) u_dut_a (
        .clk_100m(clk_100m), .rstn(rstn), .raw_in(raw_a),
        .level(a_level), .press_pulse(a_press), .release_pulse(a_rel),
        .long_pulse(a_long), .long_held(a_held)
    );

    button_conditioner #(
        .NUM_CH(NCH), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)
    ) u_dut_b (
        .clk_100m(clk_100m), .rstn(rstn), .raw_in(raw_b),
        .level(b_level), .press_pulse(b_press), .release_pulse(b_rel),
        .long_pulse(b_long), .long_held(b_held)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pad history delayed by the synchroniser, accepted level
    // flips after DEB+1 consecutive disagreeing samples, hold age since press.
    bit m_hist [2][NCH][3];
    bit m_acc  [2][NCH];
    int m_run  [2][NCH];
    int m_age  [2][NCH];
    bit m_held [2][NCH];
    bit m_press[2][NCH];
    bit m_rel  [2][NCH];
    bit m_long [2][NCH];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                m_hist[d][c][0] = 1'b0;
                m_hist[d][c][1] = (d == 1);
                m_hist[d][c][2] = (d == 1);
                m_acc[d][c]   = 1'b0;
                m_run[d][c]   = 0;
                m_age[d][c]   = 0;
                m_held[d][c]  = 1'b0;
                m_press[d][c] = 1'b0;
                m_rel[d][c]   = 1'b0;
                m_long[d][c]  = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                bit s;
                bit rawv;
                s = m_hist[d][c][0];
                m_hist[d][c][0] = m_hist[d][c][1];
                m_hist[d][c][1] = m_hist[d][c][2];
                rawv = (d == 0) ? raw_a[c] : raw_b[c];
                m_hist[d][c][2] = rawv ^ bit'(d == 1);
                m_press[d][c] = 1'b0;
                m_rel[d][c]   = 1'b0;
                m_long[d][c]  = 1'b0;
                if (s != m_acc[d][c]) m_run[d][c]++;
                else                  m_run[d][c] = 0;
                if (m_run[d][c] == int'(DEB) + 1) begin
                    m_run[d][c] = 0;
                    m_acc[d][c] = s;
                    if (s) begin
                        m_press[d][c] = 1'b1;
                        m_age[d][c]   = 0;
                    end else begin
                        m_rel[d][c]  = 1'b1;
                        m_held[d][c] = 1'b0;
                    end
                end else if (m_acc[d][c] && m_age[d][c] < int'(LNG) - 1) begin
                    m_age[d][c]++;
                    if (m_age[d][c] == int'(LNG) - 1) begin
                        m_long[d][c] = 1'b1;
                        m_held[d][c] = 1'b1;
                    end
                end
            end
        end
    endtask

    always @(posedge clk_100m or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    function automatic logic [NCH-1:0] mvec(input int d, input int kind);
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) begin
            case (kind)
                0:       v[c] = m_acc[d][c];
                1:       v[c] = m_press[d][c];
                2:       v[c] = m_rel[d][c];
                3:       v[c] = m_long[d][c];
                default: v[c] = m_held[d][c];
            endcase
        end
        return v;
    endfunction

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk_100m) begin
        check_val("A_level",   32'(a_level), 32'(mvec(0, 0)));
        check_val("A_press",   32'(a_press), 32'(mvec(0, 1)));
        check_val("A_release", 32'(a_rel),   32'(mvec(0, 2)));
        check_val("A_long",    32'(a_long),  32'(mvec(0, 3)));
        check_val("A_held",    32'(a_held),  32'(mvec(0, 4)));
        check_val("B_level",   32'(b_level), 32'(mvec(1, 0)));
        check_val("B_press",   32'(b_press), 32'(mvec(1, 1)));
        check_val("B_release", 32'(b_rel),   32'(mvec(1, 2)));
        check_val("B_long",    32'(b_long),  32'(mvec(1, 3)));
        check_val("B_held",    32'(b_held),  32'(mvec(1, 4)));
    end

    task automatic set_raw(input int d, input int ch, input bit pressed);
        if (d == 0) raw_a[ch] = pressed;
        else        raw_b[ch] = ~pressed;
    endtask

    // Press one channel at edge 0, optionally glitch it low, release at 'hold';
    // report edge offsets of the first press/long/release strobe (-1 if none).
    task automatic watch(input int d, input int ch, input int hold, input int g_at,
                         input int g_len, input int total,
                         output int p, output int l, output int r);
        p = -1; l = -1; r = -1;
        set_raw(d, ch, 1'b1);
        for (int e = 0; e < total; e++) begin
            @(posedge clk_100m); #1;
            if (((d == 0) ? a_press[ch] : b_press[ch]) && p < 0) p = e;
            if (((d == 0) ? a_long[ch]  : b_long[ch])  && l < 0) l = e;
            if (((d == 0) ? a_rel[ch]   : b_rel[ch])   && r < 0) r = e;
            if (e + 1 == hold)                 set_raw(d, ch, 1'b0);
            else if (e + 1 == g_at)            set_raw(d, ch, 1'b0);
            else if (e + 1 == g_at + g_len)    set_raw(d, ch, 1'b1);
        end
    endtask

    initial begin
        int p, l, r;
        raw_a = 4'hF;
        raw_b = 4'hF;
        rstn  = 1'b1;
        #1 rstn = 1'b0;

        // Reset with all pads active: everything quiet, then a joint press at edge 11.
        repeat (3) @(posedge clk_100m);
        #1;
        check_val("rst_a_level", 32'(a_level), 32'h0);
        check_val("rst_a_press", 32'(a_press), 32'h0);
        check_val("rst_a_held",  32'(a_held),  32'h0);
        check_val("rst_b_level", 32'(b_level), 32'h0);
        @(negedge clk_100m) rstn = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            @(posedge clk_100m); #1;
            if (e == 10) check_val("t1_press_e10", 32'(a_press), 32'h0);
            if (e == 11) begin
                check_val("t1_press_e11", 32'(a_press), 32'hF);
                check_val("t1_level_e11", 32'(a_level), 32'hF);
            end
        end
        raw_a = 4'h0;
        repeat (20) @(posedge clk_100m);
        #1 check_val("t1_all_released", 32'(a_level), 32'h0);

        // Short glitch on ch0 is rejected.
        watch(0, 0, 5, -1, 0, 25, p, l, r);
        check_val("t2_glitch_press", 32'(p), 32'hFFFF_FFFF);
        check_val("t2_level0", 32'(a_level[0]), 32'h0);

        // Clean press/long/release on ch1.
        watch(0, 1, 40, -1, 0, 60, p, l, r);
        check_val("t3_press_at", 32'(p), 32'd11);
        check_val("t3_long_at",  32'(l), 32'd42);
        check_val("t3_rel_at",   32'(r), 32'd51);
        check_val("t3_held_clr", 32'(a_held[1]), 32'h0);

        // Release glitch on ch2 leaves press and long timing intact.
        watch(0, 2, 1000, 20, 4, 50, p, l, r);
        check_val("t4_press_at", 32'(p), 32'd11);
        check_val("t4_long_at",  32'(l), 32'd42);
        check_val("t4_no_rel",   32'(r), 32'hFFFF_FFFF);
        check_val("t4_level2",   32'(a_level[2]), 32'h1);
        set_raw(0, 2, 1'b0);
        repeat (15) @(posedge clk_100m);
        #1;

        // Active-low instance: short hold, release before long.
        watch(1, 0, 20, -1, 0, 40, p, l, r);
        check_val("t5_press_at", 32'(p), 32'd11);
        check_val("t5_rel_at",   32'(r), 32'd31);
        check_val("t5_no_long",  32'(l), 32'hFFFF_FFFF);

        // Async reset while pressed; a still-held pad is a fresh press.
        watch(0, 3, 1000, -1, 0, 15, p, l, r);
        check_val("t6_press_at", 32'(p), 32'd11);
        @(posedge clk_100m); #3 rstn = 1'b0;
        #1;
        check_val("t6_rst_level", 32'(a_level), 32'h0);
        check_val("t6_rst_press", 32'(a_press), 32'h0);
        @(negedge clk_100m) rstn = 1'b1;
        watch(0, 3, 1000, -1, 0, 15, p, l, r);
        check_val("t6_repress_at", 32'(p), 32'd11);
        set_raw(0, 3, 1'b0);
        repeat (15) @(posedge clk_100m);
        #1;

        // Randomized pad activity at varying toggle rates, with one reset burst.
        for (int seg = 0; seg < 10; seg++) begin
            int unsigned rate;
            rate = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 14 : 70);
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_100m); #1;
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(rate - 1, 0) == 0) raw_a[c] = ~raw_a[c];
                    if ($urandom_range(rate - 1, 0) == 0) raw_b[c] = ~raw_b[c];
                end
                if (seg == 5 && i == 100) rstn = 1'b0;
                if (seg == 5 && i == 102) rstn = 1'b1;
            end
        end

        @(posedge clk_100m); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
